// File: rtl/win_ctrl_pkg.sv
// Shared types and constants for the 3x3 window fetch controller.
// Tap k sits at row k/3 and column k%3 of the window; offsets are stored biased by +1.
package win_ctrl_pkg;

    localparam int TAPS       = 9;
    localparam int K_W        = 4;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 19;
    localparam int COORD_W    = 9;

    localparam logic [K_W-1:0] REUSE_STEPS = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_RESULT,
        ST_WRITE,
        ST_ADVANCE,
        ST_DONE
    } state_e;

    localparam logic [1:0] TAP_DX1 [TAPS] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    localparam logic [1:0] TAP_DY1 [TAPS] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};

endpackage

// File: rtl/win_addr_gen.sv
// Combinational SRAM address generator: tap read address around (x, y),
// or the output-region write address for (x, y).
module win_addr_gen
    import win_ctrl_pkg::*;
#(
    parameter int IMG_W    = 512,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OUT_BASE = 262144
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [K_W-1:0]     tap,
    input  logic               wr,
    output logic [ADDR_W-1:0]  addr
);

    localparam int SHIFT = $clog2(IMG_W);

    logic [K_W-1:0]    tap_i;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    always_comb begin
        tap_i = (tap < K_W'(TAPS)) ? tap : '0;
        row   = ADDR_W'(y);
        col   = ADDR_W'(x);
        if (!wr) begin
            // x, y >= 1, so subtracting the bias never underflows
            row = row + ADDR_W'(TAP_DY1[tap_i]) - ADDR_W'(1);
            col = col + ADDR_W'(TAP_DX1[tap_i]) - ADDR_W'(1);
        end
        addr = (row << SHIFT) + col + (wr ? ADDR_W'(OUT_BASE) : '0);
    end

endmodule

// File: rtl/win_fetch_ctrl.sv
// Owns the image SRAM during 3x3 filtering: fetches taps, presents windows, writes results back.
// Build option COLUMN_REUSE_EN: shift the window left within a row and fetch only the new column.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing tap reads, capturing read data one cycle later
// PRESENT | window offered to the filter
// RESULT  | waiting for the filtered pixel
// WRITE   | writing the result to the output region
// ADVANCE | stepping to the next centre in raster order
// DONE    | one-cycle completion pulse
module win_fetch_ctrl
    import win_ctrl_pkg::*;
#(
    parameter int IMG_W    = 512,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int X_MAX    = 510,
    parameter int Y_MAX    = 510,
    parameter int OUT_BASE = 262144
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     sram_csn,
    output logic                     sram_wen,
    output logic [ADDR_W-1:0]        sram_a,
    output logic [DATA_W-1:0]        sram_din,
    input  logic [DATA_W-1:0]        sram_dout,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [TAPS*DATA_W-1:0]   win_data,
    output logic [COORD_W-1:0]       win_x,
    output logic [COORD_W-1:0]       win_y,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [DATA_W-1:0]        res_data
);

    state_e                         state_q, state_d;
    logic [K_W-1:0]                 k_q, k_d;
    logic [COORD_W-1:0]             x_q, x_d;
    logic [COORD_W-1:0]             y_q, y_d;
    logic [TAPS-1:0][DATA_W-1:0]    tap_q, tap_d;
    logic [DATA_W-1:0]              res_q, res_d;
    logic                           reuse_q, reuse_d;

    logic                           acc;
    logic                           wr;
    logic [K_W-1:0]                 last_k;
    logic [K_W-1:0]                 tap_sel;
    logic [K_W-1:0]                 cap_sel;
    logic [ADDR_W-1:0]              addr;

    win_addr_gen #(
        .IMG_W    (IMG_W),
        .ADDR_W   (ADDR_W),
        .OUT_BASE (OUT_BASE)
    ) u_addr_gen (
        .x    (x_q),
        .y    (y_q),
        .tap  (tap_sel),
        .wr   (wr),
        .addr (addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= COORD_W'(1);
            y_q     <= COORD_W'(1);
            tap_q   <= '0;
            res_q   <= '0;
            reuse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tap_q   <= tap_d;
            res_q   <= res_d;
            reuse_q <= reuse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        tap_d   = tap_q;
        res_d   = res_q;
        reuse_d = reuse_q;
        acc     = 1'b0;
        wr      = 1'b0;
        // A reused window only fetches the right-hand column: taps 2, 5, 8
        last_k  = reuse_q ? REUSE_STEPS : K_W'(TAPS);
        tap_sel = reuse_q ? (k_q * 4'd3 + 4'd2) : k_q;
        cap_sel = reuse_q ? ((k_q - 4'd1) * 4'd3 + 4'd2) : (k_q - 4'd1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    x_d     = COORD_W'(1);
                    y_d     = COORD_W'(1);
                    k_d     = '0;
                    reuse_d = 1'b0;
                end
            end
            ST_FETCH: begin
                acc = (k_q != last_k);
                if (k_q != '0 && cap_sel < K_W'(TAPS)) begin
                    tap_d[cap_sel] = sram_dout;
                end
                if (k_q == last_k) begin
                    state_d = ST_PRESENT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_PRESENT: begin
                if (win_ready) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_valid) begin
                    res_d   = res_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                acc     = 1'b1;
                wr      = 1'b1;
                state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                k_d     = '0;
                reuse_d = 1'b0;
                if (x_q == COORD_W'(X_MAX) && y_q == COORD_W'(Y_MAX)) begin
                    state_d = ST_DONE;
                end else if (x_q == COORD_W'(X_MAX)) begin
                    x_d     = COORD_W'(1);
                    y_d     = y_q + 9'd1;
                    state_d = ST_FETCH;
                end else begin
                    x_d     = x_q + 9'd1;
                    state_d = ST_FETCH;
`ifdef COLUMN_REUSE_EN
                    reuse_d = 1'b1;
                    for (int r = 0; r < 3; r++) begin
                        tap_d[3*r]   = tap_q[3*r+1];
                        tap_d[3*r+1] = tap_q[3*r+2];
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sram_csn  = ~acc;
    assign sram_wen  = wr;
    assign sram_a    = acc ? addr : '0;
    assign sram_din  = wr ? res_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign win_valid = (state_q == ST_PRESENT);
    assign res_ready = (state_q == ST_RESULT);
    assign win_data  = tap_q;
    assign win_x     = x_q;
    assign win_y     = y_q;

endmodule
